// File: rtl/dytr2_pkg.sv
// Shared types and constants for the DyTR2 recovery controller.
package dytr2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    RECOVER = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam int DEF_N         = 8;
  localparam int DEF_REC_LEN   = 2;
  localparam int DEF_MAX_RETRY = 3;
  localparam int DEF_CNT_W     = 8;

  localparam logic MODE_SAVE = 1'b1;
  localparam logic MODE_CMP  = 1'b0;

endpackage

// File: rtl/dytr2_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module dytr2_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/dytr2_ctrl.sv
// DyTR2 recovery controller: drives modeS, detects compare-phase mismatches,
// runs bounded rollback/replay and escalates to HALT after repeated failures.
module dytr2_ctrl
  import dytr2_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int REC_LEN   = DEF_REC_LEN,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [N-1:0]     fail,
  output logic             modeS,
  output logic             hold,
  output logic             recovering,
  output logic             halt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N-1:0]     fail_map
);

  localparam logic [3:0] REC_INIT  = 4'(REC_LEN - 1);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_t     state, state_nx;
  logic       ph, ph_nx;
  logic [2:0] retry, retry_nx;
  logic [3:0] rec_cnt, rec_cnt_nx;
  logic       det;
  logic       retry_ok;

  assign det      = (state == CHECK) && ph && (|fail);
  assign retry_ok = ({1'b0, retry} + 4'd1) < RETRY_LIM;

  always_comb begin
    state_nx   = state;
    ph_nx      = ph;
    retry_nx   = retry;
    rec_cnt_nx = rec_cnt;
    if (clr) begin
      // clear wins over everything, including a coincident detection
      state_nx   = en ? CHECK : IDLE;
      ph_nx      = 1'b0;
      retry_nx   = '0;
      rec_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state_nx = CHECK;
            ph_nx    = 1'b0;
          end
        end
        CHECK: begin
          if (!ph) begin
            ph_nx = 1'b1;
          end else if (det) begin
            ph_nx = 1'b0;
            if (retry_ok) begin
              state_nx   = RECOVER;
              retry_nx   = retry + 3'd1;
              rec_cnt_nx = REC_INIT;
            end else begin
              state_nx = HALT;
            end
          end else begin
            ph_nx    = 1'b0;
            retry_nx = '0;
            if (!en)
              state_nx = IDLE;
          end
        end
        RECOVER: begin
          if (rec_cnt == 4'd0) begin
            state_nx = CHECK;
            ph_nx    = 1'b0;
          end else begin
            rec_cnt_nx = rec_cnt - 4'd1;
          end
        end
        HALT: begin
          state_nx = HALT;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ph         <= 1'b0;
      retry      <= '0;
      rec_cnt    <= '0;
      modeS      <= MODE_SAVE;
      hold       <= 1'b0;
      recovering <= 1'b0;
      halt       <= 1'b0;
      fail_map   <= '0;
    end else begin
      state      <= state_nx;
      ph         <= ph_nx;
      retry      <= retry_nx;
      rec_cnt    <= rec_cnt_nx;
      case (state_nx)
        IDLE:    modeS <= MODE_SAVE;
        CHECK:   modeS <= ph_nx ? MODE_CMP : MODE_SAVE;
        default: modeS <= MODE_CMP;
      endcase
      hold       <= (state_nx == RECOVER) || (state_nx == HALT);
      recovering <= (state_nx == RECOVER);
      halt       <= (state_nx == HALT);
      if (clr)
        fail_map <= '0;
      else if (det)
        fail_map <= fail_map | fail;
    end
  end

  dytr2_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (det && !clr),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_dytr2_ctrl.sv
// Directed self-checking bench for dytr2_ctrl (default instance plus a narrow-counter instance).
module tb_dytr2_ctrl;
  import dytr2_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr;
  logic [7:0] fail;
  logic       modeS, hold, recovering, halt;
  logic [7:0] err_cnt, fail_map;

  logic       s_en, s_clr;
  logic [7:0] s_fail;
  logic       s_modeS, s_hold, s_recovering, s_halt;
  logic [1:0] s_err_cnt;
  logic [7:0] s_fail_map;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dytr2_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .fail(fail),
    .modeS(modeS), .hold(hold), .recovering(recovering), .halt(halt),
    .err_cnt(err_cnt), .fail_map(fail_map)
  );

  dytr2_ctrl #(.N(8), .REC_LEN(2), .MAX_RETRY(7), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(s_en), .clr(s_clr), .fail(s_fail),
    .modeS(s_modeS), .hold(s_hold), .recovering(s_recovering), .halt(s_halt),
    .err_cnt(s_err_cnt), .fail_map(s_fail_map)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; fail = 8'h00;
    s_en = 1'b0; s_clr = 1'b0; s_fail = 8'h00;
    tick();
    chk("rst_modeS", 32'(modeS), 1);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_recovering", 32'(recovering), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_fail_map", 32'(fail_map), 0);
    rst = 1'b0;
    tick();
    chk("idle_modeS", 32'(modeS), 1);

    // clean run: modeS alternates 1,0 starting with the save phase
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("clean_modeS", 32'(modeS), (i % 2 == 0) ? 1 : 0);
      chk("clean_hold", 32'(hold), 0);
    end
    chk("clean_err_cnt", 32'(err_cnt), 0);

    // single detection in compare phase
    fail = 8'h04;
    tick();
    fail = 8'h00;
    chk("det1_recovering", 32'(recovering), 1);
    chk("det1_hold", 32'(hold), 1);
    chk("det1_modeS", 32'(modeS), 0);
    chk("det1_err_cnt", 32'(err_cnt), 1);
    chk("det1_fail_map", 32'(fail_map), 8'h04);
    tick();
    chk("det1_rec2", 32'(recovering), 1);
    tick();
    chk("det1_rec_done", 32'(recovering), 0);
    chk("det1_resume_modeS", 32'(modeS), 1);
    chk("det1_resume_hold", 32'(hold), 0);
    tick();
    chk("det1_cmp_modeS", 32'(modeS), 0);
    tick();
    chk("det1_clean_modeS", 32'(modeS), 1);

    // three back-to-back detections: retry must have been cleared, so halt on the third
    for (int d = 0; d < 3; d++) begin
      tick();
      fail = 8'h01;
      tick();
      fail = 8'h00;
      chk("rep_err_cnt", 32'(err_cnt), 2 + d);
      chk("rep_fail_map", 32'(fail_map), 8'h05);
      chk("rep_recovering", 32'(recovering), (d < 2) ? 1 : 0);
      chk("rep_halt", 32'(halt), (d == 2) ? 1 : 0);
      if (d < 2) begin
        tick();
        tick();
        chk("rep_resume_modeS", 32'(modeS), 1);
      end
    end
    fail = 8'hFF;
    for (int i = 0; i < 10; i++) tick();
    fail = 8'h00;
    chk("halt_persist", 32'(halt), 1);
    chk("halt_hold", 32'(hold), 1);
    chk("halt_modeS", 32'(modeS), 0);
    chk("halt_err_cnt", 32'(err_cnt), 4);
    chk("halt_fail_map", 32'(fail_map), 8'h05);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_halt", 32'(halt), 0);
    chk("clr_hold", 32'(hold), 0);
    chk("clr_modeS", 32'(modeS), 1);
    chk("clr_err_cnt", 32'(err_cnt), 0);
    chk("clr_fail_map", 32'(fail_map), 0);

    // fail during save phase and during IDLE is ignored
    fail = 8'hFF;
    tick();
    fail = 8'h00;
    chk("ph0_recovering", 32'(recovering), 0);
    chk("ph0_modeS", 32'(modeS), 0);
    tick();
    chk("ph0_err_cnt", 32'(err_cnt), 0);
    en = 1'b0;
    tick();
    chk("leave_modeS", 32'(modeS), 0);
    tick();
    chk("idle_back_modeS", 32'(modeS), 1);
    fail = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_modeS_ff", 32'(modeS), 1);
      chk("idle_err_cnt", 32'(err_cnt), 0);
    end
    fail = 8'h00;
    chk("idle_fail_map", 32'(fail_map), 0);

    // clear coinciding with a detection discards it
    en = 1'b1;
    tick();
    tick();
    chk("pre_clr_modeS", 32'(modeS), 0);
    fail = 8'h02;
    clr = 1'b1;
    tick();
    fail = 8'h00;
    clr = 1'b0;
    chk("clrdet_recovering", 32'(recovering), 0);
    chk("clrdet_err_cnt", 32'(err_cnt), 0);
    chk("clrdet_fail_map", 32'(fail_map), 0);
    chk("clrdet_modeS", 32'(modeS), 1);

    // asynchronous reset in the second recovery cycle
    tick();
    fail = 8'h08;
    tick();
    fail = 8'h00;
    chk("arst_rec1", 32'(recovering), 1);
    tick();
    chk("arst_rec2", 32'(recovering), 1);
    rst = 1'b1;
    #1;
    chk("arst_modeS", 32'(modeS), 1);
    chk("arst_hold", 32'(hold), 0);
    chk("arst_recovering", 32'(recovering), 0);
    chk("arst_err_cnt", 32'(err_cnt), 0);
    chk("arst_fail_map", 32'(fail_map), 0);
    tick();
    rst = 1'b0;
    en = 1'b0;

    // narrow counter saturates at 3 over five spaced detections
    s_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      s_fail = 8'h10;
      tick();
      s_fail = 8'h00;
      chk("sat_recovering", 32'(s_recovering), 1);
      chk("sat_err_cnt", 32'(s_err_cnt), (i < 3) ? i + 1 : 3);
      tick();
      tick();
      tick();
      tick();
    end
    chk("sat_halt", 32'(s_halt), 0);
    chk("sat_fail_map", 32'(s_fail_map), 8'h10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
